// File: rtl/collision_detector_pkg.sv
// Shared physics package: default geometry, rectangle-table layout,
// contact-vector bit positions, scan FSM encoding and a margin helper.
package collision_detector_pkg;

    // Default geometry (position units) and table size
    localparam int DEF_N_RECT   = 8;
    localparam int DEF_PLAYER_W = 32;
    localparam int DEF_PLAYER_H = 64;
    localparam int DEF_MARGIN   = 4;

    // rect_wdata layout: {valid, is_platform, x_min, x_max, y_min, y_max}
    localparam int COORD_W        = 32;
    localparam int RECT_W         = 130;
    localparam int RECT_VALID_BIT = 129;
    localparam int RECT_PLAT_BIT  = 128;
    localparam int RECT_XMIN_LSB  = 96;
    localparam int RECT_XMAX_LSB  = 64;
    localparam int RECT_YMIN_LSB  = 32;
    localparam int RECT_YMAX_LSB  = 0;

    // Bit positions inside a per-player contact vector
    localparam int N_HIT  = 5;
    localparam int HIT_L  = 4;
    localparam int HIT_R  = 3;
    localparam int HIT_U  = 2;
    localparam int HIT_D  = 1;
    localparam int HIT_PD = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SNAP   = 2'd1,
        ST_SCAN   = 2'd2,
        ST_UPDATE = 2'd3
    } state_t;

    // True when |diff| <= margin; diff is wide enough that it never wraps
    function automatic logic within_margin(input logic signed [33:0] diff,
                                           input int margin);
        logic signed [33:0] lim;
        lim = 34'(margin);
        return (diff <= lim) && (diff >= -lim);
    endfunction

endpackage

// File: rtl/collision_detector_collision_test.sv
// One rectangle against one player box: the five contact flags plus the
// raw vertical-overlap term. Purely combinational.
module collision_test
    import collision_detector_pkg::*;
#(
    parameter int PLAYER_W = DEF_PLAYER_W,
    parameter int PLAYER_H = DEF_PLAYER_H,
    parameter int MARGIN   = DEF_MARGIN
) (
    input  logic               i_valid,
    input  logic               i_is_platform,
    input  logic signed [31:0] i_px,
    input  logic signed [31:0] i_py,
    input  logic signed [31:0] i_x_min,
    input  logic signed [31:0] i_x_max,
    input  logic signed [31:0] i_y_min,
    input  logic signed [31:0] i_y_max,
    output logic               o_wall_l,
    output logic               o_wall_r,
    output logic               o_wall_u,
    output logic               o_wall_d,
    output logic               o_platf_d,
    output logic               o_vov
);

    // Edges widened to 33 bits so px+W / py+H cannot wrap
    logic signed [32:0] w_px, w_py, w_px_end, w_py_end;
    logic signed [32:0] w_xmin, w_xmax, w_ymin, w_ymax;
    // Edge-to-edge distances; one more bit because two 33-bit edges can
    // differ by more than 2^32
    logic signed [33:0] w_d_bot, w_d_top, w_d_left, w_d_right;
    logic w_hov, w_vov;
    logic w_near_bot, w_near_top, w_near_left, w_near_right;
    logic w_solid, w_plat;

    assign w_px     = 33'(i_px);
    assign w_py     = 33'(i_py);
    assign w_px_end = w_px + 33'(PLAYER_W);
    assign w_py_end = w_py + 33'(PLAYER_H);
    assign w_xmin   = 33'(i_x_min);
    assign w_xmax   = 33'(i_x_max);
    assign w_ymin   = 33'(i_y_min);
    assign w_ymax   = 33'(i_y_max);

    assign w_hov = (w_px < w_xmax) && (w_px_end > w_xmin);
    assign w_vov = (w_py < w_ymax) && (w_py_end > w_ymin);

    assign w_d_bot   = 34'(w_py_end) - 34'(w_ymin);
    assign w_d_top   = 34'(w_py)     - 34'(w_ymax);
    assign w_d_left  = 34'(w_px)     - 34'(w_xmax);
    assign w_d_right = 34'(w_px_end) - 34'(w_xmin);

    assign w_near_bot   = within_margin(w_d_bot,   MARGIN);
    assign w_near_top   = within_margin(w_d_top,   MARGIN);
    assign w_near_left  = within_margin(w_d_left,  MARGIN);
    assign w_near_right = within_margin(w_d_right, MARGIN);

    // An empty slot never produces contact of any kind
    assign w_solid = i_valid & ~i_is_platform;
    assign w_plat  = i_valid &  i_is_platform;

    assign o_wall_d  = w_solid & w_hov & w_near_bot;
    assign o_wall_u  = w_solid & w_hov & w_near_top;
    assign o_wall_l  = w_solid & w_vov & w_near_left;
    assign o_wall_r  = w_solid & w_vov & w_near_right;
    assign o_platf_d = w_plat  & w_hov & w_near_bot;
    assign o_vov     = i_valid & w_vov;

endmodule

// File: rtl/collision_detector.sv
// Two-player collision scanner. On a call it snapshots both players, walks
// the rectangle table one slot per cycle testing both players in parallel,
// then publishes the OR-ed contacts and pulses done.
module collision_detector
    import collision_detector_pkg::*;
#(
    parameter int N_RECT   = DEF_N_RECT,
    parameter int PLAYER_W = DEF_PLAYER_W,
    parameter int PLAYER_H = DEF_PLAYER_H,
    parameter int MARGIN   = DEF_MARGIN,
    localparam int ADDR_W  = (N_RECT > 1) ? $clog2(N_RECT) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                call,
    input  logic [63:0]         pos1,
    input  logic [63:0]         pos2,
    input  logic                drop1,
    input  logic                drop2,
    input  logic                rect_we,
    input  logic [ADDR_W-1:0]   rect_addr,
    input  logic [RECT_W-1:0]   rect_wdata,
    output logic                wallL1,
    output logic                wallR1,
    output logic                wallU1,
    output logic                wallD1,
    output logic                platfD1,
    output logic                platfT1,
    output logic                wallL2,
    output logic                wallR2,
    output logic                wallU2,
    output logic                wallD2,
    output logic                platfD2,
    output logic                platfT2,
    output logic                busy,
    output logic                done
);

    // Table rounded up to a power of two so any rect_addr is in range;
    // slots beyond N_RECT are never scanned
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_RECT - 1);

    state_t r_state, w_state_next;
    logic   w_snap, w_scan, w_update;

    logic [ADDR_W-1:0] r_index;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_we;

    // Geometry lives in an array without reset; valid bits sit beside it
    // in flops so reset can empty the table in one cycle
    logic [RECT_W-2:0] r_mem [DEPTH];
    logic [RECT_W-2:0] r_rd_data;
    logic [DEPTH-1:0]  r_valid;
    logic              r_rd_valid;

    logic signed [31:0] w_x_min, w_x_max, w_y_min, w_y_max;
    logic               w_rect_plat;

    logic              r_done;
    logic [63:0]       w_pos_in  [2];
    logic              w_drop_in [2];
    logic [N_HIT:0]    w_out     [2];

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; call only matters in IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (call) w_state_next = ST_SNAP;
            ST_SNAP:   w_state_next = ST_SCAN;
            ST_SCAN:   if (r_index == LAST_IDX) w_state_next = ST_UPDATE;
            ST_UPDATE: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Per-state control strobes
    always_comb begin
        busy     = 1'b0;
        w_snap   = 1'b0;
        w_scan   = 1'b0;
        w_update = 1'b0;
        case (r_state)
            ST_SNAP:   begin busy = 1'b1; w_snap   = 1'b1; end
            ST_SCAN:   begin busy = 1'b1; w_scan   = 1'b1; end
            ST_UPDATE: begin busy = 1'b1; w_update = 1'b1; end
            default:   ;
        endcase
    end

    // Scan index: cleared on SNAP, advanced once per SCAN cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            r_index <= '0;
        end else if (w_snap) begin
            r_index <= '0;
        end else if (w_scan) begin
            r_index <= (r_index == LAST_IDX) ? '0 : r_index + ADDR_W'(1);
        end
    end

    // Prefetch address: slot 0 during SNAP, then the slot after the one
    // being tested, so the registered read is always one step ahead
    assign w_rd_addr = (w_scan && (r_index != LAST_IDX)) ? r_index + ADDR_W'(1) : '0;
    assign w_we      = rect_we && (r_state == ST_IDLE);

    // Table geometry: write in IDLE, registered read
    always_ff @(posedge clock) begin
        if (w_we) begin
            r_mem[rect_addr] <= rect_wdata[RECT_W-2:0];
        end
        r_rd_data <= r_mem[w_rd_addr];
    end

    // Table valid bits: cleared on reset, registered read alongside geometry
    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid    <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_we) begin
                r_valid[rect_addr] <= rect_wdata[RECT_VALID_BIT];
            end
            r_rd_valid <= r_valid[w_rd_addr];
        end
    end

    assign w_rect_plat = r_rd_data[RECT_PLAT_BIT];
    assign w_x_min     = $signed(r_rd_data[RECT_XMIN_LSB +: COORD_W]);
    assign w_x_max     = $signed(r_rd_data[RECT_XMAX_LSB +: COORD_W]);
    assign w_y_min     = $signed(r_rd_data[RECT_YMIN_LSB +: COORD_W]);
    assign w_y_max     = $signed(r_rd_data[RECT_YMAX_LSB +: COORD_W]);

    assign w_pos_in[0]  = pos1;
    assign w_pos_in[1]  = pos2;
    assign w_drop_in[0] = drop1;
    assign w_drop_in[1] = drop2;

    for (genvar gi = 0; gi < 2; gi++) begin : g_player
        logic signed [31:0] r_px, r_py;
        logic               r_drop;
        logic [N_HIT-1:0]   r_acc, r_flags, w_hit;
        logic               r_eng, r_platf_t;
        logic               w_vov, w_eng;

        collision_test #(
            .PLAYER_W (PLAYER_W),
            .PLAYER_H (PLAYER_H),
            .MARGIN   (MARGIN)
        ) u_test (
            .i_valid       (r_rd_valid),
            .i_is_platform (w_rect_plat),
            .i_px          (r_px),
            .i_py          (r_py),
            .i_x_min       (w_x_min),
            .i_x_max       (w_x_max),
            .i_y_min       (w_y_min),
            .i_y_max       (w_y_max),
            .o_wall_l      (w_hit[HIT_L]),
            .o_wall_r      (w_hit[HIT_R]),
            .o_wall_u      (w_hit[HIT_U]),
            .o_wall_d      (w_hit[HIT_D]),
            .o_platf_d     (w_hit[HIT_PD]),
            .o_vov         (w_vov)
        );

        // The player is still engaged with a platform while overlapping it
        // vertically or resting on it; resting counts so a drop request
        // issued while standing on the platform is not cancelled at once
        assign w_eng = (w_vov & w_rect_plat) | w_hit[HIT_PD];

        // Snapshot on SNAP, accumulate on SCAN, publish on UPDATE
        always_ff @(posedge clock) begin
            if (reset) begin
                r_px      <= '0;
                r_py      <= '0;
                r_drop    <= 1'b0;
                r_acc     <= '0;
                r_eng     <= 1'b0;
                r_flags   <= '0;
                r_platf_t <= 1'b0;
            end else begin
                if (w_snap) begin
                    r_px   <= w_pos_in[gi][63:32];
                    r_py   <= w_pos_in[gi][31:0];
                    r_drop <= w_drop_in[gi];
                    r_acc  <= '0;
                    r_eng  <= 1'b0;
                end
                if (w_scan) begin
                    r_acc <= r_acc | w_hit;
                    r_eng <= r_eng | w_eng;
                end
                if (w_update) begin
                    r_flags   <= r_acc;
                    // losing the platform clears, otherwise drop-on-platform sets
                    r_platf_t <= r_eng & (r_platf_t | (r_drop & r_flags[HIT_PD]));
                end
            end
        end

        assign w_out[gi] = {r_flags, r_platf_t};
    end

    // done is raised together with the freshly published flags
    always_ff @(posedge clock) begin
        if (reset) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_update;
        end
    end

    assign done    = r_done;
    assign wallL1  = w_out[0][HIT_L  + 1];
    assign wallR1  = w_out[0][HIT_R  + 1];
    assign wallU1  = w_out[0][HIT_U  + 1];
    assign wallD1  = w_out[0][HIT_D  + 1];
    assign platfD1 = w_out[0][HIT_PD + 1];
    assign platfT1 = w_out[0][0];
    assign wallL2  = w_out[1][HIT_L  + 1];
    assign wallR2  = w_out[1][HIT_R  + 1];
    assign wallU2  = w_out[1][HIT_U  + 1];
    assign wallD2  = w_out[1][HIT_D  + 1];
    assign platfD2 = w_out[1][HIT_PD + 1];
    assign platfT2 = w_out[1][0];

endmodule
